sys_array_feeder_bfloat_16: RTL

Upstream sequencer for the 2x2 bfloat16 systolic array. It latches one 2x2 matrix A and one 2x2 matrix B on a start handshake. It then drives the array's row/column edge inputs in the standard skewed (diagonal-wavefront) order, one `load_in` pulse per beat. It waits for the array's `valid_op` and reports completion, or a timeout, back to the controller.

---
 rtl/sys_array_feeder_bfloat_16.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sys_array_feeder_bfloat_16.sv
// Upstream sequencer for a 2x2 bfloat16 systolic array: latches A and B on
// a start handshake, feeds them in skewed wavefront order, then awaits valid_op.
module sys_array_feeder_bfloat_16 #(
  parameter int STEP_CYCLES = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a00,
  input  logic [15:0] a01,
  input  logic [15:0] a10,
  input  logic [15:0] a11,
  input  logic [15:0] b00,
  input  logic [15:0] b01,
  input  logic [15:0] b10,
  input  logic [15:0] b11,
  input  logic        array_valid_op,
  output logic        ready,
  output logic        busy,
  output logic [15:0] row_in_row0,
  output logic [15:0] row_in_row1,
  output logic [15:0] col_in_col0,
  output logic [15:0] col_in_col1,
  output logic        load_in,
  output logic        done,
  output logic        timeout_err
);

  localparam logic [7:0]  STEP_LAST = 8'(STEP_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FEED, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  beat, beat_nxt;
  logic [7:0]  step, step_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic        err_flag, err_nxt;
  logic        accept;

  logic [15:0] a00_q, a01_q, a10_q, a11_q;
  logic [15:0] b00_q, b01_q, b10_q, b11_q;
  logic [15:0] row0_d, row1_d, col0_d, col1_d;

  // ready is the registered view of IDLE, so a start is taken only once the
  // controller has actually been able to see ready high.
  assign accept = (state == IDLE) && ready && start;

  // NOTE: state and counters use non-blocking assignments so every register
  // samples the pre-edge values of all others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= '0;
      step     <= '0;
      wait_cnt <= '0;
      err_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat     <= beat_nxt;
      step     <= step_nxt;
      wait_cnt <= wait_cnt_nxt;
      err_flag <= err_nxt;
    end
  end

  // NOTE: every variable gets its hold value first so no path through the
  // case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_nxt    = state;
    beat_nxt     = beat;
    step_nxt     = step;
    wait_cnt_nxt = wait_cnt;
    err_nxt      = err_flag;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = FEED;
          beat_nxt  = '0;
          step_nxt  = '0;
          err_nxt   = 1'b0;
        end
      end
      FEED: begin
        if (step == STEP_LAST) begin
          step_nxt = '0;
          if (beat == 2'd3) begin
            state_nxt    = WAIT;
            beat_nxt     = '0;
            wait_cnt_nxt = '0;
          end else begin
            beat_nxt = beat + 2'd1;
          end
        end else begin
          step_nxt = step + 8'd1;
        end
      end
      WAIT: begin
        if (array_valid_op) begin
          state_nxt = DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 16'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Skewed wavefront: row i carries A[i][beat-i], column j carries B[beat-j][j].
  always_comb begin
    row0_d = '0;
    row1_d = '0;
    col0_d = '0;
    col1_d = '0;
    if (state == FEED) begin
      unique case (beat)
        2'd0: begin
          row0_d = a00_q;
          col0_d = b00_q;
        end
        2'd1: begin
          row0_d = a01_q;
          row1_d = a10_q;
          col0_d = b10_q;
          col1_d = b01_q;
        end
        2'd2: begin
          row1_d = a11_q;
          col1_d = b11_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {a00_q, a01_q, a10_q, a11_q} <= '0;
      {b00_q, b01_q, b10_q, b11_q} <= '0;
    end else if (accept) begin
      {a00_q, a01_q, a10_q, a11_q} <= {a00, a01, a10, a11};
      {b00_q, b01_q, b10_q, b11_q} <= {b00, b01, b10, b11};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready       <= 1'b1;
      busy        <= 1'b0;
      load_in     <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      row_in_row0 <= '0;
      row_in_row1 <= '0;
      col_in_col0 <= '0;
      col_in_col1 <= '0;
    end else begin
      ready       <= (state == IDLE);
      busy        <= (state == FEED) || (state == WAIT);
      load_in     <= (state == FEED) && (step == '0);
      done        <= (state == DONE);
      timeout_err <= err_flag;
      row_in_row0 <= row0_d;
      row_in_row1 <= row1_d;
      col_in_col0 <= col0_d;
      col_in_col1 <= col1_d;
    end
  end

endmodule
